// File: rtl/encrypt_stream_if.sv
// Stream-side signals of encrypt_stream: frame control, plaintext, keystream and ciphertext handshakes.
// The bench or upstream logic uses the master modport; the cipher block uses the slave modport.
interface encrypt_stream_if #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 16384
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BEAT_W = CHANNELS * DATA_W;

  logic              start;
  logic              bypass;
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic              key_valid;
  logic              key_ready;
  logic [BEAT_W-1:0] key_data;
  logic              out_valid;
  logic              out_ready;
  logic [BEAT_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    output start, bypass, in_valid, in_data, key_valid, key_data, out_ready,
    input  in_ready, key_ready, out_valid, out_data, out_addr, out_last, busy, done
  );

  modport slave (
    input  start, bypass, in_valid, in_data, key_valid, key_data, out_ready,
    output in_ready, key_ready, out_valid, out_data, out_addr, out_last, busy, done
  );
endinterface

// File: rtl/encrypt_stream.sv
// Frame-oriented XOR stream cipher: pairs each plaintext beat with one keystream beat
// and emits the ciphertext through a single output register tagged with its beat index.
module encrypt_stream #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 16384
) (
  input  logic           clk,
  input  logic           rst,
  encrypt_stream_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BEAT_W = CHANNELS * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q;
  logic              bypass_q;
  logic              space;
  logic              in_rdy;
  logic              key_rdy;
  logic              accept;

  logic              vld_p1;
  logic [BEAT_W-1:0] data_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              last_p1;

  function automatic logic [BEAT_W-1:0] encrypt_beat(
    input logic [BEAT_W-1:0] pt,
    input logic [BEAT_W-1:0] ks,
    input logic              pass
  );
    logic [BEAT_W-1:0] ct;
    ct = pt;
    if (!pass) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ct[c*DATA_W +: DATA_W] = pt[c*DATA_W +: DATA_W] ^ ks[c*DATA_W +: DATA_W];
      end
    end
    return ct;
  endfunction

  // Readies never look at their own valid, so upstream cannot form a combinational loop.
  always_comb begin
    space   = !vld_p1 || bus.out_ready;
    in_rdy  = (state_q == RUN) && (bus.key_valid || bypass_q) && space;
    key_rdy = (state_q == RUN) && bus.in_valid && !bypass_q && space;
    accept  = in_rdy && bus.in_valid;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (accept && (count_q == LAST_IDX)) state_d = FLUSH;
      FLUSH:   if (!vld_p1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      bypass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && bus.start) begin
        bypass_q <= bus.bypass;
        count_q  <= '0;
      end else if (accept && (count_q != LAST_IDX)) begin
        count_q <= count_q + ADDR_W'(1);
      end
    end
  end

  // Stage p1: ciphertext output register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      addr_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= encrypt_beat(bus.in_data, bus.key_data, bypass_q);
      addr_p1 <= count_q;
      last_p1 <= (count_q == LAST_IDX);
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.key_ready = key_rdy;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_addr  = addr_p1;
  assign bus.out_last  = last_p1;
  assign bus.busy      = (state_q == RUN) || (state_q == FLUSH);
  assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_encrypt_stream.sv
// Scoreboard bench for encrypt_stream: an input model queues expected ciphertext on each
// accepted beat, and an output monitor pops and compares whenever a beat leaves the DUT.
module tb_encrypt_stream;
  localparam int DATA_W   = 8;
  localparam int CHANNELS = 3;
  localparam int DEPTH    = 4;
  localparam int BEAT_W   = DATA_W * CHANNELS;

  typedef struct {
    logic [BEAT_W-1:0] data;
    int                addr;
    bit                last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encrypt_stream_if #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus ();
  encrypt_stream #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [BEAT_W-1:0] pt_arr  [DEPTH];
  logic [BEAT_W-1:0] key_arr [DEPTH];
  exp_t              exp_q   [$];

  bit                gap_chk   = 1'b0;
  bit                stall_chk = 1'b0;
  bit                idle_chk  = 1'b0;
  bit                run_chk   = 1'b0;
  bit                timed_out = 1'b0;
  bit                const_on  = 1'b0;
  bit                thr_on    = 1'b0;
  logic [BEAT_W-1:0] const_val = '0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Input model: every accepted plaintext beat defines one expected ciphertext beat.
  int m_idx = 0;
  bit byp_m = 1'b0;
  always @(negedge clk) begin
    bit fi, fk;
    exp_t e;
    if (rst) begin
      m_idx = 0;
    end else begin
      if (bus.start && !bus.busy && !bus.done) begin
        m_idx = 0;
        byp_m = bus.bypass;
      end
      if (bus.busy) begin
        fi = bus.in_valid && bus.in_ready;
        fk = bus.key_valid && bus.key_ready;
        if (byp_m) chk("key_ready_bypass", 64'(bus.key_ready), 64'(0));
        else if (fi || fk) chk("pair_consume", 64'(fk), 64'(fi));
        if (fi) begin
          chk("in_overrun", 64'(m_idx < DEPTH), 64'(1));
          if (m_idx < DEPTH) begin
            e.data = byp_m ? pt_arr[m_idx] : (pt_arr[m_idx] ^ key_arr[m_idx]);
            e.addr = m_idx;
            e.last = (m_idx == DEPTH - 1);
            exp_q.push_back(e);
            m_idx++;
          end
        end
      end
    end
  end

  // Output monitor.
  int                rd_ptr    = 0;
  int                mcyc      = 0;
  int                last_fire = -1;
  bit                prev_stall = 1'b0;
  bit                prev_done  = 1'b0;
  logic [BEAT_W-1:0] hold_data;
  logic [63:0]       hold_addr;
  logic              hold_last;
  always @(negedge clk) begin
    exp_t e;
    mcyc++;
    if (!thr_on) last_fire = -1;
    if (rst) begin
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_out_data",  64'(bus.out_data),  64'(0));
      chk("rst_out_addr",  64'(bus.out_addr),  64'(0));
      chk("rst_out_last",  64'(bus.out_last),  64'(0));
      chk("rst_busy",      64'(bus.busy),      64'(0));
      chk("rst_done",      64'(bus.done),      64'(0));
      chk("rst_in_ready",  64'(bus.in_ready),  64'(0));
      chk("rst_key_ready", 64'(bus.key_ready), 64'(0));
      rd_ptr     = exp_q.size();
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (!bus.busy) begin
        chk("idle_in_ready",  64'(bus.in_ready),  64'(0));
        chk("idle_key_ready", 64'(bus.key_ready), 64'(0));
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_data",  64'(bus.out_data),  64'(hold_data));
        chk("hold_addr",  64'(bus.out_addr),  hold_addr);
        chk("hold_last",  64'(bus.out_last),  64'(hold_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (rd_ptr < exp_q.size()) begin
          e = exp_q[rd_ptr];
          rd_ptr++;
          chk("out_data", 64'(bus.out_data), 64'(e.data));
          chk("out_addr", 64'(bus.out_addr), 64'(e.addr));
          chk("out_last", 64'(bus.out_last), 64'(e.last));
        end else begin
          chk("out_unexpected", 64'(1), 64'(0));
        end
        if (const_on) chk("const_data", 64'(bus.out_data), 64'(const_val));
        if (thr_on && last_fire >= 0) chk("throughput", 64'(mcyc - last_fire), 64'(1));
        if (thr_on) last_fire = mcyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      hold_data  = bus.out_data;
      hold_addr  = 64'(bus.out_addr);
      hold_last  = bus.out_last;
      if (bus.done) begin
        chk("done_single",  64'(prev_done), 64'(0));
        chk("done_drained", 64'(exp_q.size() - rd_ptr), 64'(0));
        chk("done_outv",    64'(bus.out_valid), 64'(0));
      end
      prev_done = bus.done;
      if (gap_chk) chk("gap_in_ready", 64'(bus.in_ready), 64'(0));
      if (stall_chk) begin
        chk("stall_in_ready",  64'(bus.in_ready),  64'(0));
        chk("stall_key_ready", 64'(bus.key_ready), 64'(0));
      end
      if (idle_chk) begin
        chk("restart_idle_busy", 64'(bus.busy), 64'(0));
        chk("restart_idle_done", 64'(bus.done), 64'(0));
      end
      if (run_chk) chk("restart_run_busy", 64'(bus.busy), 64'(1));
      if (timed_out) chk("frame_timeout", 64'(1), 64'(0));
    end
  end

  function automatic bit roll(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic fill(input int pattern);
    for (int i = 0; i < DEPTH; i++) begin
      case (pattern)
        1:       begin pt_arr[i] = 24'h112233; key_arr[i] = 24'h0F0F0F; end
        2:       begin pt_arr[i] = 24'hABCDEF; key_arr[i] = BEAT_W'($urandom); end
        default: begin pt_arr[i] = BEAT_W'($urandom); key_arr[i] = BEAT_W'($urandom); end
      endcase
    end
  endtask

  // mode: 0 plain, 1 keystream gap, 2 output stall, 3 reset mid-frame, 4 start held high
  task automatic run_frame(input bit byp, input int pct, input int mode, input bit do_start);
    int idx = 0;
    int kidx = 0;
    int n = 0;
    int gap = 0;
    int stall = 0;
    bit fin = 1'b0;
    bit fi, fk;
    if (do_start) begin
      bus.bypass = byp;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start  = (mode == 4);
    end
    while (!fin && n < 200) begin
      gap_chk   = 1'b0;
      stall_chk = 1'b0;
      bus.in_valid  = (idx < DEPTH) && roll(pct);
      bus.in_data   = (idx < DEPTH) ? pt_arr[idx] : BEAT_W'($urandom);
      bus.key_valid = byp ? roll(pct) : ((kidx < DEPTH) && roll(pct));
      bus.key_data  = (!byp && kidx < DEPTH) ? key_arr[kidx] : BEAT_W'($urandom);
      bus.out_ready = roll(pct);
      if (mode == 1 && idx == 2 && gap < 3) begin
        bus.in_valid  = 1'b1;
        bus.key_valid = 1'b0;
        bus.out_ready = 1'b1;
        gap_chk = 1'b1;
        gap++;
      end
      if (mode == 2 && idx >= 1 && stall < 5 && bus.out_valid) begin
        bus.out_ready = 1'b0;
        stall_chk = 1'b1;
        stall++;
      end
      @(negedge clk);
      fi = bus.in_valid && bus.in_ready;
      fk = bus.key_valid && bus.key_ready;
      if (bus.done) fin = 1'b1;
      @(posedge clk); #1;
      if (fi) idx++;
      if (fk) kidx++;
      n++;
      if (mode == 3 && idx == 2) begin
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        fin = 1'b1;
      end
    end
    gap_chk       = 1'b0;
    stall_chk     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.key_valid = 1'b0;
    bus.out_ready = 1'b1;
    if (!fin) begin
      timed_out = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      timed_out = 1'b0;
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.bypass    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.key_valid = 1'b0;
    bus.key_data  = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    fill(1);
    const_on = 1'b1; const_val = 24'h1E2D3C; thr_on = 1'b1;
    run_frame(1'b0, 100, 0, 1'b1);
    const_on = 1'b0; thr_on = 1'b0;

    fill(0);
    run_frame(1'b0, 100, 1, 1'b1);

    fill(0);
    run_frame(1'b0, 100, 2, 1'b1);

    fill(2);
    const_on = 1'b1; const_val = 24'hABCDEF; thr_on = 1'b1;
    run_frame(1'b1, 100, 0, 1'b1);
    const_on = 1'b0; thr_on = 1'b0;

    fill(0);
    run_frame(1'b0, 100, 3, 1'b1);
    fill(0);
    run_frame(1'b0, 100, 0, 1'b1);

    fill(0);
    run_frame(1'b0, 100, 4, 1'b1);
    fill(0);
    bus.bypass = 1'b0;
    idle_chk = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    idle_chk  = 1'b0;
    bus.start = 1'b0;
    run_chk   = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    run_chk = 1'b0;
    run_frame(1'b0, 100, 0, 1'b0);

    for (int f = 0; f < 12; f++) begin
      fill(0);
      run_frame(1'($urandom_range(1)), 70, 0, 1'b1);
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
